// File: rtl/rv32i_types.sv
// Shared type definitions for the RV32I memory subsystem.
// Holds the cache arbiter state and grant encodings.
// Other files pull these in with import rv32i_types::*.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_req_latch.sv
// Purpose: captures address, write data and op of the granted request.
// Latency: value visible the cycle after load is asserted.
// Backpressure: none; load is driven only when the arbiter accepts a grant.
module arb_req_latch #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [LINE_W-1:0] wdata_d,
  input  logic              op_write_d,
  output logic [ADDR_W-1:0] addr_q,
  output logic [LINE_W-1:0] wdata_q,
  output logic              op_write_q
);

  // Load-enabled capture register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else if (load) begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Purpose: round-robin share of one physical-memory port between I-cache and D-cache.
// Latency: command on pmem_* the cycle after the grant edge; resp is combinational with pmem_resp.
// Backpressure: one outstanding transaction; requesters hold their request until their resp.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  grant_t            last_grant;
  logic              d_req;
  logic              pick_d;
  logic              load;
  logic              serving;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;

  // Grant decision: D wins if alone, or if both ask and I was served last.
  always_comb begin
    d_req  = d_read | d_write;
    pick_d = d_req & (~i_read | (last_grant == GRANT_I));
    load   = (state == IDLE) & (i_read | d_req);
  end

  // A D request with both read and write set is treated as a write-back.
  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_req_latch (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .addr_d     (pick_d ? d_address : i_address),
    .wdata_d    (pick_d ? d_wdata : '0),
    .op_write_d (pick_d & d_write),
    .addr_q     (lat_addr),
    .wdata_q    (lat_wdata),
    .op_write_q (lat_write)
  );

  // FSM: grant from IDLE, return to IDLE on the memory completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= SERVE_D;
            last_grant <= GRANT_D;
          end else if (i_read) begin
            state      <= SERVE_I;
            last_grant <= GRANT_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: everything is gated by state so reset drops the command at once.
  always_comb begin
    serving      = (state != IDLE);
    pmem_read    = serving & ~lat_write;
    pmem_write   = (state == SERVE_D) & lat_write;
    pmem_address = serving ? lat_addr : '0;
    pmem_wdata   = serving ? lat_wdata : '0;
    i_resp       = (state == SERVE_I) & pmem_resp;
    d_resp       = (state == SERVE_D) & pmem_resp;
    i_rdata      = i_resp ? pmem_rdata : '0;
    d_rdata      = d_resp ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: randomized and directed check of cache_arbiter against a transaction-level model.
// Latency: model expects the command one cycle after the grant edge and resp with pmem_resp.
// Backpressure: memory latency is randomized; requesters hold until resp.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_d;  // model: most recent grant went to D
  logic won;
  logic [LW-1:0] line;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  a_onehot_resp: assert property (@(posedge clk) disable iff (!rst) !(i_resp && d_resp));
  a_cmd_excl:    assert property (@(posedge clk) disable iff (!rst) !(pmem_read && pmem_write));
  a_cmd_stable:  assert property (@(posedge clk) disable iff (!rst)
                   (pmem_read || pmem_write) && !pmem_resp |=>
                   $stable(pmem_read) && $stable(pmem_write) &&
                   $stable(pmem_address) && $stable(pmem_wdata));
  a_d_proto:     assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & 32'hffff_ffe0;
  endfunction

  // One transaction with the requests already driven; called just after a negedge.
  task automatic do_txn(input int lat, output logic won_d);
    logic          ed, ew;
    logic [AW-1:0] ea;
    logic [LW-1:0] edat, ln;
    ed   = (d_read || d_write) && (!i_read || !last_d);
    ew   = ed && d_write;
    ea   = ed ? d_address : i_address;
    edat = ed ? d_wdata : '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("cmd_read",  pmem_read,  !ew);
    check("cmd_write", pmem_write, ew);
    check("cmd_addr",  pmem_address, ea);
    check("cmd_wdata", pmem_wdata, edat);
    for (int k = 0; k < lat; k++) begin
      if (ed) d_address = rand_addr(); else i_address = rand_addr();
      @(negedge clk);
      #1;
      check("hold_addr", pmem_address, ea);
      check("hold_op", {pmem_read, pmem_write}, {!ew, ew});
    end
    ln = rand_line();
    pmem_rdata = ln;
    pmem_resp  = 1'b1;
    #1;
    check("i_resp",  i_resp, !ed);
    check("d_resp",  d_resp, ed);
    check("i_rdata", i_rdata, ed ? '0 : ln);
    check("d_rdata", d_rdata, ed ? ln : '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("idle_cmd",  {pmem_read, pmem_write}, 2'b00);
    check("idle_resp", {i_resp, d_resp}, 2'b00);
    if (ed) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    last_d = ed;
    won_d  = ed;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_read = 1'b1; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = 32'h40; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    last_d = 1'b0;
    // Reset: a request held across edges must not reach memory.
    repeat (2) @(posedge clk);
    #2;
    check("rst_cmd", {pmem_read, pmem_write}, 2'b00);
    check("rst_addr", pmem_address, '0);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    i_read = 1'b0;
    rst = 1'b1;
    #1;

    // Both requesting continuously from reset: D first, then strict alternation.
    i_read = 1'b1; i_address = rand_addr();
    d_read = 1'b1; d_address = rand_addr(); d_wdata = rand_line();
    for (int t = 0; t < 6; t++) begin
      do_txn($urandom_range(0, 2), won);
      check("alt_grant", won, (t % 2) == 0);
      if (won) begin d_read = 1'b1; d_address = rand_addr(); end
      else     begin i_read = 1'b1; i_address = rand_addr(); end
    end
    do_txn(0, won);
    do_txn(0, won);

    // I only, memory answers three cycles after the command.
    i_read = 1'b1; i_address = 32'h0000_0040;
    do_txn(3, won);
    // D write-back.
    d_write = 1'b1; d_address = 32'h8000_0100; d_wdata = rand_line();
    do_txn(2, won);

    // Spurious pmem_resp in IDLE.
    pmem_rdata = rand_line();
    pmem_resp  = 1'b1;
    #1;
    check("spur_resp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    #1;
    check("spur_state", {pmem_read, pmem_write}, 2'b00);
    pmem_resp = 1'b0;

    // D read withdrawn mid-transaction still completes with one pulse.
    d_read = 1'b1; d_address = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("wd_cmd", pmem_read, 1'b1);
    d_read = 1'b0;
    repeat (2) @(negedge clk);
    line = rand_line();
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    #1;
    check("wd_resp", d_resp, 1'b1);
    check("wd_rdata", d_rdata, line);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("wd_once", d_resp, 1'b0);
    last_d = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1'b1; i_address = rand_addr();
      end
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
        d_address = rand_addr(); d_wdata = rand_line();
      end
      if (!i_read && !d_read && !d_write) begin
        i_read = 1'b1; i_address = rand_addr();
      end
      do_txn($urandom_range(0, 3), won);
    end
    while (i_read || d_read || d_write) do_txn(0, won);

    // Asynchronous reset during a D write-back.
    d_write = 1'b1; d_address = 32'h8000_0200; d_wdata = rand_line();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("ar_cmd", pmem_write, 1'b1);
    rst = 1'b0;
    #1;
    check("ar_drop", {pmem_read, pmem_write}, 2'b00);
    check("ar_addr", pmem_address, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; d_write = 1'b0; last_d = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("ar_late_resp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("ar_idle", {pmem_read, pmem_write}, 2'b00);

    // After reset the round-robin pointer favours D again.
    i_read = 1'b1; i_address = rand_addr();
    d_read = 1'b1; d_address = rand_addr();
    do_txn(1, won);
    check("ar_grant", won, 1'b1);
    do_txn(1, won);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
